miinst_issue_sequencer: RTL and testbench
=========================================

// Module: miinst_issue_sequencer
// PURPOSE
//  Sits between fetch_phase decode and execute. Buffers micro-instruction bundles (miinst_t[MQ_N])
//  produced per x86 instruction and issues their non-NOP slots one per cycle, in slot order, over
//  a valid/ready handshake. Drops all-NOP bundles (prefix bytes) and supports a flush on redirect.
// PARAMETERS
//  MQ_N   4  slots per bundle; equals the `MQ_N define
//  DEPTH  2  bundle FIFO entries; power of two, >=2
// PORTS
//  clk         in   1               clock; all state changes on rising edge
//  rstn        in   1               asynchronous, active-low reset
//  flush       in   1               discard all buffered/in-flight bundles (jump/redirect)
//  in_valid    in   1               in_bundle is a complete decoded bundle
//  in_ready    out  1               FIFO can accept a bundle this cycle
//  in_bundle   in   MQ_N x miinst_t slot 0..MQ_N-1; opcode MIOP_NOP = empty slot
//  out_valid   out  1               out_miinst is a valid uop
//  out_ready   in   1               execute accepts out_miinst
//  out_miinst  out  miinst_t        current uop
//  out_last    out  1               out_miinst is the last non-NOP slot of its bundle
//  busy        out  1               FIFO non-empty
// BEHAVIOUR
//  - Reset (async, rstn=0): FIFO count=0, wr/rd ptr=0, slot idx=0, state=IDLE; out_valid=0,
//    out_last=0, busy=0, out_miinst=NOP; in_ready=1 once rstn=1. Reset mid-issue drops everything.
//  - FSM: IDLE (count==0) -> ISSUE on accepted push; ISSUE -> IDLE when last bundle popped and
//    no push same cycle, or on flush.
//  - Push: in_valid&&in_ready writes bundle at wr_ptr. in_ready = (count<DEPTH); no comb. path
//    from out_ready. Push+pop in same cycle: count unchanged; pointers wrap mod DEPTH.
//  - Head select: nxt = lowest slot >= idx of head bundle with opcode!=MIOP_NOP.
//    out_valid = busy && nxt exists; out_miinst = head[nxt]; out_last = no non-NOP slot > nxt.
//  - Beat (out_valid&&out_ready): if out_last, pop head, idx<=0; else idx<=nxt+1.
//  - All-NOP head (or no non-NOP at/after idx): popped in one cycle, out_valid=0 that cycle.
//  - Hold: while out_valid&&!out_ready, out_miinst/out_last stay stable, idx unchanged.
//  - Latency: bundle accepted cycle N -> first uop out_valid cycle N+1 (see CONFIGURATION).
//    Throughput: 1 uop/cycle; a bundle of k non-NOP slots occupies head for k cycles.
//  - Flush: next cycle count=0, idx=0, out_valid=0. Push in flush cycle is discarded; a
//    beat in flush cycle is still considered consumed by execute (execute squashes it).
//  - Slot order never reordered; bmd/pc fields pass through unmodified.
// CONFIGURATION
//  MIINST_ISSUE_BYPASS_EN defined: when FIFO empty, in_valid=1 and no flush, first non-NOP slot
//    of in_bundle drives out_* combinationally same cycle (latency 0); if beat taken and bundle
//    has 1 uop, nothing is written; otherwise bundle written with idx advanced past issued slot.
//  Not defined: no in->out combinational path; latency exactly 1 cycle.
// STRUCTURE
//  - Shared package/params header: miinst_t, miop_t (MIOP_NOP), bmd_t, `MQ_N, and a
//    nop_miinst constant used for reset/idle out_miinst.
//  - One sub-module: miinst_slot_pick (comb.): inputs bundle + idx, outputs nxt, found, is_last.
//    Instanced once for head (and once for in_bundle under MIINST_ISSUE_BYPASS_EN).
// TESTING
//  1 Reset: rstn=0 mid-issue with count=2 -> out_valid=0, busy=0, in_ready=1 immediately.
//  2 Bundle {ADDI,NOP,JR,NOP}, out_ready=1 -> ADDI(out_last=0) cycle 1, JR(out_last=1) cycle 2,
//    busy=0 cycle 3.
//  3 Prefix bundle all NOP followed by {MOVI,NOP,NOP,NOP} -> no beat for first, MOVI with
//    out_last=1 one cycle later; no NOP ever appears with out_valid=1.
//  4 DEPTH=2, out_ready=0, push 3 bundles -> in_ready=0 after 2nd; raise out_ready with
//    in_valid=1 -> push accepted in pop cycle only when count<2, order preserved.
//  5 Flush while issuing slot 1 of 3-uop bundle with 2nd bundle queued -> out_valid=0 next
//    cycle, busy=0, same-cycle push discarded.
//  6 Back-pressure: out_ready toggles 0/1 each cycle on 4-uop bundle -> out_miinst stable
//    during stalls, 4 beats over 8 cycles; with MIINST_ISSUE_BYPASS_EN first uop on push cycle.

Source files
------------

// File: rtl/miinst_issue_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : miinst_issue_sequencer_pkg
// Brief   : Micro-instruction types, slot-count define and FSM encodings.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef MQ_N
`define MQ_N 4
`endif

package miinst_issue_sequencer_pkg;

   typedef enum logic [3:0] {
      MIOP_NOP  = 4'd0,
      MIOP_ADDI = 4'd1,
      MIOP_MOVI = 4'd2,
      MIOP_JR   = 4'd3,
      MIOP_LD   = 4'd4,
      MIOP_ST   = 4'd5
   } miop_t;

   typedef struct packed {
      logic [3:0] len;
      logic [3:0] flags;
   } bmd_t;

   typedef struct packed {
      miop_t       op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [15:0] imm;
      bmd_t        bmd;
      logic [31:0] pc;
   } miinst_t;

   localparam miinst_t c_nop_miinst = '{op: MIOP_NOP, default: '0};

   typedef logic [0:0] state_t;
   localparam state_t c_st_idle  = 1'b0;
   localparam state_t c_st_issue = 1'b1;

endpackage

`default_nettype wire

// File: rtl/miinst_issue_sequencer_slot_pick.sv
`default_nettype none
// ============================================================================
// Module  : miinst_slot_pick
// Brief   : Finds the lowest non-NOP slot at or after idx and flags it as last
//           when no non-NOP slot follows it.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef MQ_N
`define MQ_N 4
`endif

module miinst_slot_pick
   import miinst_issue_sequencer_pkg::*;
#(
   parameter int MQ_N = `MQ_N,
   parameter int IDXW = (MQ_N > 1) ? $clog2(MQ_N) : 1
) (
   input  miinst_t [MQ_N-1:0] bundle_i,
   input  logic [IDXW-1:0]    idx_i,
   output logic [IDXW-1:0]    nxt_o,
   output logic               found_o,
   output logic               is_last_o
);

   always_comb begin
      nxt_o   = '0;
      found_o = 1'b0;
      // Descending scan so the lowest qualifying slot wins.
      for (int i = MQ_N - 1; i >= 0; i--) begin
         if ((i >= int'(idx_i)) && (bundle_i[i].op != MIOP_NOP)) begin
            nxt_o   = IDXW'(i);
            found_o = 1'b1;
         end
      end
   end

   always_comb begin
      is_last_o = 1'b1;
      for (int i = 0; i < MQ_N; i++) begin
         if ((i > int'(nxt_o)) && (bundle_i[i].op != MIOP_NOP)) begin
            is_last_o = 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/miinst_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : miinst_issue_sequencer
// Brief   : Bundle FIFO issuing non-NOP micro-instructions one per cycle.
//           Optional same-cycle bypass when empty: MIINST_ISSUE_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef MQ_N
`define MQ_N 4
`endif

module miinst_issue_sequencer
   import miinst_issue_sequencer_pkg::*;
#(
   parameter int MQ_N  = `MQ_N,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  miinst_t [MQ_N-1:0] in_bundle,
   output logic               out_valid,
   input  logic               out_ready,
   output miinst_t            out_miinst,
   output logic               out_last,
   output logic               busy
);

   localparam int IDXW = (MQ_N > 1) ? $clog2(MQ_N) : 1;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);

   miinst_t [MQ_N-1:0] mem_q [DEPTH];
   miinst_t [MQ_N-1:0] w_head;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [IDXW-1:0] idx_q, idx_d;

   logic [IDXW-1:0] w_h_nxt;
   logic            w_h_found, w_h_last;
   logic            w_push, w_wr, w_beat, w_pop;

   assign w_head   = mem_q[rd_ptr_q];
   assign in_ready = (count_q < CW'(DEPTH));
   assign busy     = (count_q != '0);
   assign w_push   = in_valid && in_ready && !flush;
   assign w_beat   = out_valid && out_ready;
   assign w_pop    = (state_q == c_st_issue) && (!w_h_found || (w_beat && w_h_last));

   miinst_slot_pick #(.MQ_N(MQ_N), .IDXW(IDXW)) u_head_pick (
      .bundle_i  (w_head),
      .idx_i     (idx_q),
      .nxt_o     (w_h_nxt),
      .found_o   (w_h_found),
      .is_last_o (w_h_last)
   );

`ifdef MIINST_ISSUE_BYPASS_EN
   logic [IDXW-1:0] w_i_nxt;
   logic            w_i_found, w_i_last, w_byp;

   miinst_slot_pick #(.MQ_N(MQ_N), .IDXW(IDXW)) u_in_pick (
      .bundle_i  (in_bundle),
      .idx_i     ({IDXW{1'b0}}),
      .nxt_o     (w_i_nxt),
      .found_o   (w_i_found),
      .is_last_o (w_i_last)
   );

   assign w_byp = (count_q == '0) && in_valid && !flush;
   // A single-uop bundle consumed on its arrival cycle never enters the FIFO.
   assign w_wr  = w_push && !(w_byp && w_beat && w_i_last);
`else
   assign w_wr  = w_push;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= c_st_idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle: begin
            if (w_wr) state_d = c_st_issue;
         end
         c_st_issue: begin
            if (flush || (w_pop && !w_wr && (count_q == CW'(1)))) state_d = c_st_idle;
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_comb begin
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_miinst = c_nop_miinst;
      if (state_q == c_st_issue) begin
         if (w_h_found) begin
            out_valid  = 1'b1;
            out_last   = w_h_last;
            out_miinst = w_head[w_h_nxt];
         end
      end
`ifdef MIINST_ISSUE_BYPASS_EN
      else if (w_byp && w_i_found) begin
         out_valid  = 1'b1;
         out_last   = w_i_last;
         out_miinst = in_bundle[w_i_nxt];
      end
`endif
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      idx_d    = idx_q;
      if (w_wr)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({w_wr, w_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (w_pop) begin
         idx_d = '0;
      end else if ((state_q == c_st_issue) && w_beat) begin
         idx_d = w_h_nxt + IDXW'(1);
      end
`ifdef MIINST_ISSUE_BYPASS_EN
      if (w_byp && w_wr) begin
         idx_d = w_beat ? (w_i_nxt + IDXW'(1)) : '0;
      end
`endif
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         idx_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         idx_q    <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         idx_q    <= idx_d;
      end
   end

   // Storage carries no reset: entries are only read once count marks them valid.
   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= in_bundle;
   end

endmodule

`default_nettype wire

// File: tb/tb_miinst_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_miinst_issue_sequencer
// Brief   : Self-checking bench: uop scoreboard plus table and directed tests.
// Revision: 1.0 - initial release
// ============================================================================
module tb_miinst_issue_sequencer;
   import miinst_issue_sequencer_pkg::*;

   typedef miinst_t [3:0] bundle_t;
   typedef struct {
      miinst_t m;
      logic    last;
   } exp_t;
   typedef struct {
      bundle_t b;
      int      nuops;
   } vec_t;

`ifdef MIINST_ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic    clk = 1'b0;
   logic    rstn, flush, in_valid, in_ready, out_valid, out_ready, out_last, busy;
   bundle_t in_bundle;
   miinst_t out_miinst;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   miinst_issue_sequencer #(.MQ_N(4), .DEPTH(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bundle  (in_bundle),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_miinst (out_miinst),
      .out_last   (out_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bundle_t mk(miop_t o0, miop_t o1, miop_t o2, miop_t o3, logic [31:0] base);
      bundle_t b;
      miop_t   ops [4];
      ops = '{o0, o1, o2, o3};
      for (int i = 0; i < 4; i++) begin
         b[i]           = c_nop_miinst;
         b[i].op        = ops[i];
         b[i].rd        = 4'(i + 1);
         b[i].rs        = base[7:4];
         b[i].imm       = base[15:0] ^ 16'h5a5a;
         b[i].bmd.len   = 4'(i);
         b[i].bmd.flags = base[3:0] ^ 4'(i);
         b[i].pc        = base + 32'(i);
      end
      return b;
   endfunction

   // Scoreboard: expected uops enter on accepted push, leave on each beat.
   always @(negedge clk) begin
      if (!rstn) begin
         sb.delete();
      end else begin
         if (in_valid && in_ready && !flush) begin
            int lastidx;
            lastidx = -1;
            for (int i = 0; i < 4; i++) if (in_bundle[i].op != MIOP_NOP) lastidx = i;
            for (int i = 0; i < 4; i++) begin
               if (in_bundle[i].op != MIOP_NOP) begin
                  exp_t e;
                  e.m    = in_bundle[i];
                  e.last = (i == lastidx);
                  sb.push_back(e);
               end
            end
         end
         if (out_valid) chk("no_nop_valid", out_miinst.op == MIOP_NOP, 1'b0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_uop", {out_miinst, out_last}, {e.m, e.last});
            end
         end
         if (flush) sb.delete();
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec [5];
      int   beats;
      miinst_t prev;
      logic    rdy;

      vec[0] = '{mk(MIOP_NOP,  MIOP_NOP,  MIOP_NOP, MIOP_NOP,  32'h500), 0};
      vec[1] = '{mk(MIOP_ADDI, MIOP_NOP,  MIOP_NOP, MIOP_NOP,  32'h510), 1};
      vec[2] = '{mk(MIOP_NOP,  MIOP_NOP,  MIOP_NOP, MIOP_JR,   32'h520), 1};
      vec[3] = '{mk(MIOP_ADDI, MIOP_MOVI, MIOP_JR,  MIOP_ADDI, 32'h530), 4};
      vec[4] = '{mk(MIOP_NOP,  MIOP_MOVI, MIOP_NOP, MIOP_JR,   32'h540), 2};

      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_bundle = mk(MIOP_NOP, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h0);
      step(); step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_miinst", out_miinst, c_nop_miinst);
      rstn = 1'b1;
      step();
      chk("rst_in_ready", in_ready, 1'b1);

      // Reset while issuing with two bundles queued
      in_valid = 1'b1; in_bundle = mk(MIOP_ADDI, MIOP_MOVI, MIOP_NOP, MIOP_NOP, 32'h080);
      step();
      in_bundle = mk(MIOP_JR, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h090);
      step();
      in_valid = 1'b0; #1;
      chk("t1_busy_full", busy, 1'b1);
      chk("t1_valid_full", out_valid, 1'b1);
      rstn = 1'b0; #1;
      chk("t1_rst_valid", out_valid, 1'b0);
      chk("t1_rst_busy", busy, 1'b0);
      chk("t1_rst_in_ready", in_ready, 1'b1);
      step();
      rstn = 1'b1;
      step();

      // Two-uop bundle, execute always ready
      out_ready = 1'b1; in_valid = 1'b1;
      in_bundle = mk(MIOP_ADDI, MIOP_NOP, MIOP_JR, MIOP_NOP, 32'h100);
      #1;
      chk("t2_c0_valid", out_valid, BYP);
      step();
      in_valid = 1'b0; #1;
      chk("t2_c1_op", out_miinst.op, BYP ? MIOP_JR : MIOP_ADDI);
      chk("t2_c1_last", out_last, BYP);
      step();
      chk("t2_c2_valid", out_valid, !BYP);
      chk("t2_c2_last", out_last, !BYP);
      step();
      chk("t2_c3_busy", busy, 1'b0);

      // Prefix (all-NOP) bundle then MOVI
      in_valid = 1'b1; in_bundle = mk(MIOP_NOP, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h180);
      step();
      chk("t3_prefix_valid", out_valid, 1'b0);
      in_bundle = mk(MIOP_MOVI, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h190);
      step();
      in_valid = 1'b0; #1;
      chk("t3_movi_valid", out_valid, 1'b1);
      chk("t3_movi_op", out_miinst.op, MIOP_MOVI);
      chk("t3_movi_last", out_last, 1'b1);
      step();
      chk("t3_busy", busy, 1'b0);

      // Full FIFO: push in the pop cycle only once count drops below DEPTH
      out_ready = 1'b0; in_valid = 1'b1;
      in_bundle = mk(MIOP_MOVI, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h200);
      step();
      chk("t4_rdy1", in_ready, 1'b1);
      in_bundle = mk(MIOP_MOVI, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h210);
      step();
      chk("t4_rdy2", in_ready, 1'b0);
      in_bundle = mk(MIOP_MOVI, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h220);
      step();
      chk("t4_rdy3", in_ready, 1'b0);
      out_ready = 1'b1; #1;
      chk("t4_pc_b1", out_miinst.pc, 32'h200);
      step();
      chk("t4_rdy4", in_ready, 1'b1);
      chk("t4_pc_b2", out_miinst.pc, 32'h210);
      step();
      in_valid = 1'b0; #1;
      chk("t4_pc_b3", out_miinst.pc, 32'h220);
      step();
      chk("t4_busy", busy, 1'b0);

      // Flush on slot 1 of a 3-uop bundle with a second bundle queued
      out_ready = 1'b0; in_valid = 1'b1;
      in_bundle = mk(MIOP_ADDI, MIOP_MOVI, MIOP_JR, MIOP_NOP, 32'h300);
      step();
      in_bundle = mk(MIOP_MOVI, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h310);
      step();
      in_valid = 1'b0; out_ready = 1'b1; #1;
      chk("t5_slot0_pc", out_miinst.pc, 32'h300);
      step();
      chk("t5_slot1_pc", out_miinst.pc, 32'h301);
      flush = 1'b1; in_valid = 1'b1;
      in_bundle = mk(MIOP_ADDI, MIOP_NOP, MIOP_NOP, MIOP_NOP, 32'h320);
      step();
      flush = 1'b0; in_valid = 1'b0; #1;
      chk("t5_flush_valid", out_valid, 1'b0);
      chk("t5_flush_busy", busy, 1'b0);
      chk("t5_flush_in_ready", in_ready, 1'b1);
      step();
      chk("t5_push_dropped", busy, 1'b0);

      // Back-pressure toggling on a 4-uop bundle
      out_ready = 1'b0; in_valid = 1'b1;
      in_bundle = mk(MIOP_ADDI, MIOP_MOVI, MIOP_JR, MIOP_ADDI, 32'h400);
      #1;
      chk("t6_c0_valid", out_valid, BYP);
      step();
      in_valid = 1'b0;
      beats = 0;
      for (int i = 0; i < 8; i++) begin
         rdy = (i % 2) == 1;
         out_ready = rdy;
         #1;
         prev = out_miinst;
         if (out_valid && out_ready) beats++;
         step();
         if (!rdy) chk("t6_stall_stable", out_miinst, prev);
      end
      chk("t6_beats", beats, 4);
      chk("t6_busy", busy, 1'b0);

      // Table: one bundle at a time, count uops issued
      for (int v = 0; v < 5; v++) begin
         out_ready = 1'b1; in_valid = 1'b1; in_bundle = vec[v].b;
         #1;
         beats = (out_valid && out_ready) ? 1 : 0;
         step();
         in_valid = 1'b0;
         for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid && out_ready) beats++;
            step();
         end
         chk($sformatf("tbl%0d_uops", v), beats, vec[v].nuops);
         chk($sformatf("tbl%0d_busy", v), busy, 1'b0);
      end

      step();
      chk("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
